// File: rtl/trace_pkg.sv
// Shared types and constants for the parallel-trace sync controller.
package trace_pkg;

    typedef enum logic [1:0] {
        OFF,
        RESET_IF,
        HUNT,
        SYNCED
    } trace_state_e;

    localparam logic [31:0] TPIU_FSYNC  = 32'h7FFF_FFFF;
    localparam int          FRAME_BYTES = 16;
    localparam int          FRAME_WORDS = FRAME_BYTES / 4;

    localparam logic [1:0] WIDTH_1B   = 2'd0;
    localparam logic [1:0] WIDTH_2B   = 2'd1;
    localparam logic [1:0] WIDTH_RSVD = 2'd2;
    localparam logic [1:0] WIDTH_4B   = 2'd3;

    // The reserved encoding is never applied to the front-end.
    function automatic logic width_req_valid(input logic [1:0] w);
        return (w == WIDTH_1B) || (w == WIDTH_2B) || (w == WIDTH_4B);
    endfunction

endpackage

// File: rtl/trace_frame_buf.sv
// Two-slot ping-pong frame store: words are assembled, then the whole frame is
// committed on word 3 and streamed out byte-by-byte over valid/ready.
module trace_frame_buf
    import trace_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        wr_en_i,
    input  logic [1:0]  wr_idx_i,
    input  logic [31:0] wr_word_i,
    output logic        full_o,
    output logic        rd_valid_o,
    output logic [7:0]  rd_data_o,
    output logic        rd_last_o,
    input  logic        rd_ready_i
);

    logic [FRAME_BYTES*8-1:0]     slot_q [2];
    logic [(FRAME_WORDS-1)*32-1:0] asm_q;
    logic                          wr_slot_q, rd_slot_q;
    logic [1:0]                    cnt_q, cnt_d;
    logic [3:0]                    rd_idx_q;
    logic                          rd_done, commit, accept;

    assign rd_valid_o = (cnt_q != 2'd0);
    assign rd_last_o  = rd_valid_o && (rd_idx_q == 4'(FRAME_BYTES-1));
    assign rd_data_o  = rd_valid_o ? slot_q[rd_slot_q][{rd_idx_q, 3'b000} +: 8] : 8'h00;

    // A slot freed by this cycle's final read is usable by a frame committing now.
    assign rd_done = rd_last_o && rd_ready_i;
    assign commit  = wr_en_i && (wr_idx_i == 2'(FRAME_WORDS-1));
    assign full_o  = (cnt_q == 2'd2) && !rd_done;
    assign accept  = commit && !full_o;

    always_comb begin
        cnt_d = cnt_q;
        if (accept && !rd_done)
            cnt_d = cnt_q + 2'd1;
        else if (rd_done && !accept)
            cnt_d = cnt_q - 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 2'd0;
            wr_slot_q <= 1'b0;
            rd_slot_q <= 1'b0;
            rd_idx_q  <= 4'd0;
        end else if (flush_i) begin
            cnt_q     <= 2'd0;
            wr_slot_q <= 1'b0;
            rd_slot_q <= 1'b0;
            rd_idx_q  <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
            if (accept)
                wr_slot_q <= !wr_slot_q;
            if (rd_valid_o && rd_ready_i) begin
                rd_idx_q <= rd_idx_q + 4'd1;
                if (rd_done)
                    rd_slot_q <= !rd_slot_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i && !commit)
            asm_q[{wr_idx_i, 5'b00000} +: 32] <= wr_word_i;
        if (accept)
            slot_q[wr_slot_q] <= {wr_word_i, asm_q};
    end

endmodule

// File: rtl/trace_sync_ctrl.sv
// Parallel-trace controller: sequences the front-end, hunts TPIU full sync and
// packs the aligned byte stream into 16-byte frames for the downstream decoder.
module trace_sync_ctrl
    import trace_pkg::*;
#(
    parameter int SYNC_FRAMES_MAX = 64,
    parameter int RST_CYCLES      = 4,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_enable,
    input  logic [1:0]       cfg_width,
    output logic             if_rst,
    output logic [1:0]       if_width,
    input  logic             if_valid,
    input  logic [7:0]       if_data,
    output logic             frm_valid,
    output logic [7:0]       frm_data,
    output logic             frm_last,
    input  logic             frm_ready,
    output logic             synced,
    output logic             sync_lost,
    output logic [CNT_W-1:0] lost_frames
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int FS_W = $clog2(SYNC_FRAMES_MAX + 1);

    trace_state_e     state_q;
    logic [RC_W-1:0]  rcnt_q;
    logic [31:0]      shift_q;
    logic [23:0]      stage_q;
    logic [1:0]       phase_q, wcnt_q;
    logic [FS_W-1:0]  fss_q, fss_d;
    logic [CNT_W-1:0] lost_q;
    logic             if_rst_q, synced_q, sync_lost_q;
    logic [1:0]       if_width_q;

    logic        width_chg, byte_ok, is_fsync, buf_wr_en, frame_done, buf_full;
    logic [31:0] shift_d, word_d;

    assign width_chg  = (cfg_width != if_width_q) && width_req_valid(cfg_width);
    assign byte_ok    = cfg_enable && !width_chg && if_valid;
    assign shift_d    = {if_data, shift_q[31:8]};
    assign word_d     = {if_data, stage_q};
    assign is_fsync   = (word_d == TPIU_FSYNC);
    assign buf_wr_en  = byte_ok && (state_q == SYNCED) && (phase_q == 2'd3) && !is_fsync;
    assign frame_done = buf_wr_en && (wcnt_q == 2'(FRAME_WORDS-1));
    assign fss_d      = fss_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= OFF;
            rcnt_q      <= '0;
            shift_q     <= '0;
            stage_q     <= '0;
            phase_q     <= 2'd0;
            wcnt_q      <= 2'd0;
            fss_q       <= '0;
            lost_q      <= '0;
            if_rst_q    <= 1'b1;
            if_width_q  <= WIDTH_4B;
            synced_q    <= 1'b0;
            sync_lost_q <= 1'b0;
        end else begin
            sync_lost_q <= 1'b0;
            if (frame_done && buf_full && (lost_q != '1))
                lost_q <= lost_q + 1'b1;

            if (!cfg_enable) begin
                state_q  <= OFF;
                if_rst_q <= 1'b1;
                synced_q <= 1'b0;
            end else begin
                case (state_q)
                    OFF: begin
                        state_q  <= RESET_IF;
                        if_rst_q <= 1'b1;
                        rcnt_q   <= RC_W'(RST_CYCLES - 1);
                        if (width_req_valid(cfg_width))
                            if_width_q <= cfg_width;
                    end
                    RESET_IF: begin
                        if (rcnt_q == '0) begin
                            state_q  <= HUNT;
                            if_rst_q <= 1'b0;
                            shift_q  <= '0;
                        end else begin
                            rcnt_q <= rcnt_q - 1'b1;
                        end
                    end
                    HUNT, SYNCED: begin
                        if (width_chg) begin
                            // Partial frame is abandoned; SYNCED entry re-zeroes phase/word count.
                            state_q    <= RESET_IF;
                            if_rst_q   <= 1'b1;
                            rcnt_q     <= RC_W'(RST_CYCLES - 1);
                            if_width_q <= cfg_width;
                            synced_q   <= 1'b0;
                        end else if (if_valid) begin
                            if (state_q == HUNT) begin
                                shift_q <= shift_d;
                                if (shift_d == TPIU_FSYNC) begin
                                    state_q  <= SYNCED;
                                    synced_q <= 1'b1;
                                    phase_q  <= 2'd0;
                                    wcnt_q   <= 2'd0;
                                    fss_q    <= '0;
                                end
                            end else begin
                                phase_q <= phase_q + 2'd1;
                                if (phase_q != 2'd3) begin
                                    stage_q[{phase_q, 3'b000} +: 8] <= if_data;
                                end else if (is_fsync) begin
                                    fss_q <= '0;
                                end else begin
                                    wcnt_q <= wcnt_q + 2'd1;
                                    if (frame_done) begin
                                        fss_q <= fss_d;
                                        if (fss_d == FS_W'(SYNC_FRAMES_MAX)) begin
                                            state_q     <= HUNT;
                                            synced_q    <= 1'b0;
                                            sync_lost_q <= 1'b1;
                                            shift_q     <= '0;
                                        end
                                    end
                                end
                            end
                        end
                    end
                    default: state_q <= OFF;
                endcase
            end
        end
    end

    trace_frame_buf u_buf (
        .clk        (clk),
        .rst_n      (rst),
        .flush_i    (!cfg_enable),
        .wr_en_i    (buf_wr_en),
        .wr_idx_i   (wcnt_q),
        .wr_word_i  (word_d),
        .full_o     (buf_full),
        .rd_valid_o (frm_valid),
        .rd_data_o  (frm_data),
        .rd_last_o  (frm_last),
        .rd_ready_i (frm_ready)
    );

    assign if_rst      = if_rst_q;
    assign if_width    = if_width_q;
    assign synced      = synced_q;
    assign sync_lost   = sync_lost_q;
    assign lost_frames = lost_q;

endmodule

// File: tb/tb_trace_sync_ctrl.sv
// Bench for trace_sync_ctrl: directed scenarios plus randomized traffic, all
// compared cycle-by-cycle against a queue-based behavioural model.
module tb_trace_sync_ctrl;

    localparam int SFM      = 2;
    localparam int RSTC     = 4;
    localparam int CW       = 3;
    localparam int LOST_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_enable;
    logic [1:0]    cfg_width;
    logic          if_rst;
    logic [1:0]    if_width;
    logic          if_valid;
    logic [7:0]    if_data;
    logic          frm_valid;
    logic [7:0]    frm_data;
    logic          frm_last;
    logic          frm_ready;
    logic          synced;
    logic          sync_lost;
    logic [CW-1:0] lost_frames;

    trace_sync_ctrl #(
        .SYNC_FRAMES_MAX (SFM),
        .RST_CYCLES      (RSTC),
        .CNT_W           (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_enable  (cfg_enable),
        .cfg_width   (cfg_width),
        .if_rst      (if_rst),
        .if_width    (if_width),
        .if_valid    (if_valid),
        .if_data     (if_data),
        .frm_valid   (frm_valid),
        .frm_data    (frm_data),
        .frm_last    (frm_last),
        .frm_ready   (frm_ready),
        .synced      (synced),
        .sync_lost   (sync_lost),
        .lost_frames (lost_frames)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    endtask

    // Behavioural model: mode 0=off 1=resetting 2=hunting 3=locked.
    int           m_mode = 0;
    int           m_rem  = 0;
    bit           m_ifr  = 1'b1;
    logic [1:0]   m_ifw  = 2'd3;
    bit           m_slost = 1'b0;
    int           m_fss  = 0;
    int           m_lost = 0;
    byte unsigned m_win[$];
    byte unsigned m_stage[$];
    byte unsigned m_frame[$];
    logic [8:0]   m_out[$];

    byte unsigned tx[$];
    logic [8:0]   got[$];
    logic [8:0]   ex[$];
    int           vprob = 100;
    int           rprob = 100;
    int           n_slost = 0;

    task automatic model_locked_byte(input byte unsigned b);
        logic [31:0] w;
        m_stage.push_back(b);
        if (m_stage.size() < 4) return;
        w = {m_stage[3], m_stage[2], m_stage[1], m_stage[0]};
        m_stage.delete();
        if (w == 32'h7FFFFFFF) begin
            m_fss = 0;
            return;
        end
        for (int i = 0; i < 4; i++) m_frame.push_back(w[8*i +: 8]);
        if (m_frame.size() < 16) return;
        m_fss++;
        if ((m_out.size() + 15) / 16 < 2) begin
            for (int i = 0; i < 16; i++) m_out.push_back({(i == 15), m_frame[i]});
        end else if (m_lost < LOST_MAX) begin
            m_lost++;
        end
        m_frame.delete();
        if (m_fss == SFM) begin
            m_mode  = 2;
            m_slost = 1'b1;
            m_win.delete();
        end
    endtask

    task automatic model_step();
        m_slost = 1'b0;
        if (!cfg_enable) begin
            m_mode = 0;
            m_ifr  = 1'b1;
            m_out.delete();
            return;
        end
        if (m_out.size() > 0 && frm_ready) void'(m_out.pop_front());
        case (m_mode)
            0: begin
                m_mode = 1; m_rem = RSTC; m_ifr = 1'b1;
                if (cfg_width != 2'd2) m_ifw = cfg_width;
            end
            1: begin
                m_rem--;
                if (m_rem == 0) begin m_mode = 2; m_ifr = 1'b0; m_win.delete(); end
            end
            default: begin
                if (cfg_width != m_ifw && cfg_width != 2'd2) begin
                    m_mode = 1; m_rem = RSTC; m_ifr = 1'b1; m_ifw = cfg_width;
                end else if (if_valid) begin
                    if (m_mode == 2) begin
                        m_win.push_back(if_data);
                        if (m_win.size() > 4) void'(m_win.pop_front());
                        if (m_win.size() == 4 && m_win[0] == 8'hFF && m_win[1] == 8'hFF &&
                            m_win[2] == 8'hFF && m_win[3] == 8'h7F) begin
                            m_mode = 3; m_fss = 0;
                            m_stage.delete(); m_frame.delete();
                        end
                    end else begin
                        model_locked_byte(if_data);
                    end
                end
            end
        endcase
    endtask

    // One cycle: compare at the negedge, drive new inputs, predict, advance.
    task automatic step();
        chk("if_rst", if_rst, m_ifr);
        chk("if_width", if_width, m_ifw);
        chk("synced", synced, m_mode == 3);
        chk("sync_lost", sync_lost, m_slost);
        chk("frm_valid", frm_valid, m_out.size() > 0);
        if (m_out.size() > 0) begin
            chk("frm_data", frm_data, m_out[0][7:0]);
            chk("frm_last", frm_last, m_out[0][8]);
        end else begin
            chk("frm_last_idle", frm_last, 0);
        end
        chk("lost_frames", lost_frames, m_lost);
        if (sync_lost) n_slost++;
        if_valid  = (tx.size() > 0) && ($urandom_range(99) < vprob);
        if_data   = if_valid ? tx.pop_front() : 8'($urandom);
        frm_ready = ($urandom_range(99) < rprob);
        if (frm_valid && frm_ready) got.push_back({frm_last, frm_data});
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_idle(input int extra);
        int guard = 0;
        while (tx.size() > 0 && guard < 4000) begin step(); guard++; end
        chk("tx_drain", tx.size(), 0);
        repeat (extra) step();
    endtask

    task automatic tx_sync();
        tx.push_back(8'hFF); tx.push_back(8'hFF); tx.push_back(8'hFF); tx.push_back(8'h7F);
    endtask

    task automatic tx_frame(input byte unsigned base);
        for (int i = 0; i < 16; i++) tx.push_back(8'(base + i));
    endtask

    task automatic exp_frame(input byte unsigned base);
        for (int i = 0; i < 16; i++) ex.push_back({(i == 15), 8'(base + i)});
    endtask

    task automatic chk_got(input string tag);
        chk({tag, "_len"}, got.size(), ex.size());
        for (int i = 0; i < got.size() && i < ex.size(); i++) chk(tag, got[i], ex[i]);
        got.delete();
        ex.delete();
    endtask

    task automatic meas_rst(input string tag);
        int n = 0;
        while (if_rst && n < 20) begin n++; step(); end
        chk(tag, n, RSTC);
    endtask

    initial begin
        rst = 1'b0; cfg_enable = 1'b0; cfg_width = 2'd3;
        if_valid = 1'b0; if_data = 8'h00; frm_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_if_rst", if_rst, 1);
        chk("rst_if_width", if_width, 3);
        chk("rst_frm_valid", frm_valid, 0);
        chk("rst_frm_data", frm_data, 0);
        chk("rst_frm_last", frm_last, 0);
        chk("rst_synced", synced, 0);
        chk("rst_sync_lost", sync_lost, 0);
        chk("rst_lost", lost_frames, 0);
        rst = 1'b1;
        repeat (2) step();

        // Enable: front-end reset held for RST_CYCLES, then hunting.
        cfg_enable = 1'b1;
        step();
        meas_rst("s1_rst_len");
        chk("s1_synced", synced, 0);

        // Sync acquisition and first frame.
        got.delete();
        tx.push_back(8'h00); tx_sync(); tx_frame(8'h10);
        run_idle(25);
        chk("s2_synced", synced, 1);
        chk("s2_idle", frm_valid, 0);
        exp_frame(8'h10); chk_got("s2_out");

        // Word-aligned sync inside a frame is stripped.
        for (int i = 0; i < 8; i++) tx.push_back(8'(8'h20 + i));
        tx_sync();
        for (int i = 8; i < 16; i++) tx.push_back(8'(8'h20 + i));
        run_idle(25);
        exp_frame(8'h20); chk_got("s3_out");

        // Overflow: three frames into two slots.
        rprob = 0;
        tx_sync(); tx_frame(8'h40); tx_sync(); tx_frame(8'h60); tx_sync(); tx_frame(8'h80);
        run_idle(5);
        chk("s4_lost", lost_frames, 1);
        rprob = 100;
        run_idle(40);
        exp_frame(8'h40); exp_frame(8'h60); chk_got("s4_out");

        // Sync timeout after SYNC_FRAMES_MAX frames.
        n_slost = 0;
        tx_sync(); tx_frame(8'hA0); tx_frame(8'hB0); tx_frame(8'hC0);
        run_idle(40);
        chk("s5_slost_pulses", n_slost, 1);
        chk("s5_synced", synced, 0);
        exp_frame(8'hA0); exp_frame(8'hB0); chk_got("s5_out");

        // Width change mid-frame keeps the buffered frame.
        rprob = 0;
        tx_sync(); tx_frame(8'hD0);
        for (int i = 0; i < 6; i++) tx.push_back(8'(8'hE0 + i));
        run_idle(3);
        cfg_width = 2'd1;
        step();
        meas_rst("s6_rst_len");
        chk("s6_if_width", if_width, 1);
        rprob = 100;
        run_idle(30);
        exp_frame(8'hD0); chk_got("s6_out");

        // Drop counter saturation.
        rprob = 0;
        for (int i = 0; i < 10; i++) begin tx_sync(); tx_frame(8'(i * 16)); end
        run_idle(5);
        chk("s7_lost_sat", lost_frames, LOST_MAX);
        rprob = 100;
        run_idle(40);

        // Randomized traffic, enable toggles and width requests.
        for (int s = 0; s < 40; s++) begin
            int r;
            r = $urandom_range(99);
            vprob = $urandom_range(30, 100);
            rprob = $urandom_range(0, 100);
            cfg_enable = (r >= 8);
            if (r >= 8 && r < 18) cfg_width = 2'($urandom);
            if ($urandom_range(1) == 1) tx_sync();
            repeat ($urandom_range(4, 40)) tx.push_back(8'($urandom));
            run_idle($urandom_range(0, 10));
        end
        cfg_enable = 1'b1;
        rprob = 100;
        run_idle(40);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
